// File: rtl/acc_argmax_reader_if.sv
// acc_argmax_reader_if -- read port between the argmax reader and the accumulator RAM.
//
// Signals:
//   ram_request    reader -> RAM  read enable
//   ram_addr       reader -> RAM  read address
//   ram_read_data  RAM -> reader  read word, valid one cycle after the request cycle
//
// Modports: master (reader side), slave (RAM side).

interface acc_argmax_reader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                  ram_request;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_read_data;

  modport master (
    output ram_request,
    output ram_addr,
    input  ram_read_data
  );

  modport slave (
    input  ram_request,
    input  ram_addr,
    output ram_read_data
  );

endinterface

// File: rtl/acc_argmax_reader.sv
// acc_argmax_reader -- scans OUTPUT_CHANNEL accumulator words from a RAM with one cycle of read
// latency and reports the index and value of the largest one. Ties keep the lower index.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      single-cycle scan request, accepted only while idle
//   ram          acc_argmax_reader_if.master read port (request / address / read data)
//   busy_o       high from the cycle after an accepted start through the done cycle
//   done_o       one-cycle pulse, result valid on number_o / max_value_o
//   number_o     index of the maximum entry, held until the next result or reset
//   max_value_o  value of the maximum entry, held like number_o
//
// Build option: define ACC_SIGNED_EN to compare words as two's-complement signed values;
// otherwise they compare unsigned. Only the comparator changes.
//
// Configuration constraint: 2**ADDR_WIDTH >= OUTPUT_CHANNEL >= 1.

module acc_argmax_reader #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned OUTPUT_CHANNEL = 10,
  parameter int unsigned ADDR_WIDTH     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  acc_argmax_reader_if.master   ram,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] number_o,
  output logic [DATA_WIDTH-1:0] max_value_o
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(OUTPUT_CHANNEL - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  // Read pipeline: a word is expected on ram_read_data while rd_valid_q is set.
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  // Running maximum, internal until the done cycle.
  logic                  run_valid_q, run_valid_d;
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [ADDR_WIDTH-1:0] run_idx_q, run_idx_d;
  logic [ADDR_WIDTH-1:0] number_q, number_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  greater;
  logic                  take_word;
  logic [DATA_WIDTH-1:0] cand_max;
  logic [ADDR_WIDTH-1:0] cand_idx;

`ifdef ACC_SIGNED_EN
  assign greater = $signed(ram.ram_read_data) > $signed(run_max_q);
`else
  assign greater = ram.ram_read_data > run_max_q;
`endif

  // First word of a scan loads unconditionally; later words must be strictly greater.
  assign take_word = rd_valid_q && (!run_valid_q || greater);
  assign cand_max  = take_word ? ram.ram_read_data : run_max_q;
  assign cand_idx  = take_word ? rd_idx_q : run_idx_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_valid_d = run_valid_q | rd_valid_q;
    run_max_d   = cand_max;
    run_idx_d   = cand_idx;
    number_d    = number_q;
    max_d       = max_q;
    req         = 1'b0;
    addr        = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StIssue;
          cnt_d       = '0;
          run_valid_d = 1'b0;
        end
      end
      StIssue: begin
        req  = 1'b1;
        addr = cnt_q;
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        // Last word arrives now; fold it in and publish the result for the done cycle.
        number_d = cand_idx;
        max_d    = cand_max;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    rd_valid_d = req;
    rd_idx_d   = addr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
      run_valid_q <= 1'b0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      number_q    <= '0;
      max_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_idx_q    <= rd_idx_d;
      run_valid_q <= run_valid_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      number_q    <= number_d;
      max_q       <= max_d;
    end
  end

  assign ram.ram_request = req;
  assign ram.ram_addr    = addr;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = (state_q == StDone);
  assign number_o        = number_q;
  assign max_value_o     = max_q;

endmodule
